// File: rtl/cselect_pkg.sv
// Shared definitions for the block-serial carry-select subtractor: FSM encoding and
// helpers that derive block count and counter width from the operand geometry.
package cselect_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned num_blocks(input int unsigned m, input int unsigned n);
    return m / n;
  endfunction

  // At least one bit so a single-block configuration still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/cselect_sub_seq_if.sv
// Start/done handshake plus operand and result buses of the serial subtractor.
interface cselect_sub_seq_if #(
  parameter int unsigned M = 32
);
  logic         start;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [M-1:0] Diff;
  logic         Bout;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Bout
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bout
  );
endinterface

// File: rtl/csel_block.sv
// One N-bit carry-select slice: both carry-in candidates are formed, cin picks one.
module csel_block #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b_n,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] s0;
  logic [N:0] s1;

  always_comb begin
    s0 = {1'b0, a} + {1'b0, b_n};
    s1 = {1'b0, a} + {1'b0, b_n} + (N + 1)'(1);
    {cout, sum} = cin ? s1 : s0;
  end

endmodule

// File: rtl/cselect_sub_seq.sv
// Block-serial subtractor: Diff = A - B over M/N cycles using one time-multiplexed
// carry-select slice; the registered carry starts at 1 so A + ~B + 1 yields the difference.
module cselect_sub_seq
  import cselect_pkg::*;
#(
  parameter int unsigned M = 32,
  parameter int unsigned N = 4
) (
  input logic               clk,
  input logic               rst_n,
  cselect_sub_seq_if.slave  bus
);

  localparam int unsigned K  = num_blocks(M, N);
  localparam int unsigned CW = cnt_width(K);

  if (M % N != 0) begin : g_width_check
    $error("cselect_sub_seq: M must be a multiple of N");
  end

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [M-1:0]   a_q;
  logic [M-1:0]   bn_q;
  logic [M-1:0]   diff_q;
  logic           carry_q;
  logic           bout_q;
  logic           busy_q;
  logic           done_q;

  logic [N-1:0]   blk_a;
  logic [N-1:0]   blk_bn;
  logic [N-1:0]   blk_sum;
  logic           blk_cout;

  always_comb begin
    blk_a  = '0;
    blk_bn = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (cnt_q == CW'(i)) begin
        blk_a  = a_q[i*N +: N];
        blk_bn = bn_q[i*N +: N];
      end
    end
  end

  csel_block #(
    .N (N)
  ) u_blk (
    .a    (blk_a),
    .b_n  (blk_bn),
    .cin  (carry_q),
    .sum  (blk_sum),
    .cout (blk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      bn_q    <= '0;
      diff_q  <= '0;
      carry_q <= 1'b1;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        // DONE accepts a new start exactly like IDLE for back-to-back throughput.
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            bn_q    <= ~bus.B;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          for (int unsigned i = 0; i < K; i++) begin
            if (cnt_q == CW'(i)) diff_q[i*N +: N] <= blk_sum;
          end
          carry_q <= blk_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(K - 1)) begin
            bout_q  <= ~blk_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

endmodule
